// File: rtl/gcd_pkg.sv
// Shared constants, FSM state encodings and a reference GCD function for gcd.
package gcd_pkg;

   localparam int GCD_WIDTH = 8;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   // Modulo-based Euclid; at most a few dozen iterations for any 8-bit pair.
   function automatic logic [GCD_WIDTH-1:0] gcd_ref(input logic [GCD_WIDTH-1:0] a,
                                                    input logic [GCD_WIDTH-1:0] b);
      logic [GCD_WIDTH-1:0] p;
      logic [GCD_WIDTH-1:0] q;
      logic [GCD_WIDTH-1:0] t;
      p = a;
      q = b;
      for (int i = 0; i < 4 * GCD_WIDTH; i++) begin
         if (q != '0) begin
            t = p % q;
            p = q;
            q = t;
         end
      end
      return p;
   endfunction

endpackage

// File: rtl/gcd_step.sv
// One combinational GCD iteration: subtractive by default, binary (Stein) when
// GCD_STEIN_EN is defined, in which case a power-of-two shift count k rides along.
module gcd_step
   import gcd_pkg::*;
#(
   parameter int WIDTH = GCD_WIDTH,
   parameter int KW    = $clog2(WIDTH) + 1
) (
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
`ifdef GCD_STEIN_EN
   input  logic [KW-1:0]    k,
   output logic [KW-1:0]    next_k,
`endif
   output logic [WIDTH-1:0] next_x,
   output logic [WIDTH-1:0] next_y,
   output logic             finished,
   output logic [WIDTH-1:0] final_value
);

`ifdef GCD_STEIN_EN
   // NOTE: every output gets a default before any branch, so no path can infer a latch.
   always_comb begin
      next_x      = x;
      next_y      = y;
      next_k      = k;
      finished    = 1'b0;
      final_value = '0;
      if (x == '0) begin
         finished    = 1'b1;
         final_value = y << k;
      end else if (y == '0) begin
         finished    = 1'b1;
         final_value = x << k;
      end else if (x == y) begin
         finished    = 1'b1;
         final_value = x << k;
      end else if (!x[0] && !y[0]) begin
         next_x = x >> 1;
         next_y = y >> 1;
         next_k = k + KW'(1);
      end else if (!x[0]) begin
         next_x = x >> 1;
      end else if (!y[0]) begin
         next_y = y >> 1;
      end else if (x > y) begin
         // Difference of two odd values is even, so halve it in the same step.
         next_x = (x - y) >> 1;
      end else begin
         next_y = (y - x) >> 1;
      end
   end
`else
   // NOTE: every output gets a default before any branch, so no path can infer a latch.
   always_comb begin
      next_x      = x;
      next_y      = y;
      finished    = 1'b0;
      final_value = '0;
      if (x == '0) begin
         finished    = 1'b1;
         final_value = y;
      end else if (y == '0) begin
         finished    = 1'b1;
         final_value = x;
      end else if (x == y) begin
         finished    = 1'b1;
         final_value = x;
      end else if (x > y) begin
         next_x = x - y;
      end else begin
         next_y = y - x;
      end
   end
`endif

endmodule

// File: rtl/gcd.sv
// GCD engine: any change of a/b restarts the iteration; result/done are registered.
// Define GCD_STEIN_EN to select the binary (Stein) algorithm in gcd_step.
module gcd
   import gcd_pkg::*;
#(
   parameter int WIDTH = GCD_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output logic             done
);

   localparam int KW = $clog2(WIDTH) + 1;

   logic [1:0]       state;
   logic [WIDTH-1:0] x, y, a_lat, b_lat;
   logic [WIDTH-1:0] next_x, next_y, final_value;
   logic             finished;
   logic             restart;

   assign restart = ({a, b} != {a_lat, b_lat}) || (state == IDLE);

`ifdef GCD_STEIN_EN
   logic [KW-1:0] k, next_k;
`endif

   gcd_step #(.WIDTH(WIDTH), .KW(KW)) u_step (
      .x           (x),
      .y           (y),
`ifdef GCD_STEIN_EN
      .k           (k),
      .next_k      (next_k),
`endif
      .next_x      (next_x),
      .next_y      (next_y),
      .finished    (finished),
      .final_value (final_value)
   );

   // NOTE: non-blocking for all state, so every register sees pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         result <= '0;
         done   <= 1'b0;
         x      <= '0;
         y      <= '0;
         a_lat  <= '0;
         b_lat  <= '0;
`ifdef GCD_STEIN_EN
         k      <= '0;
`endif
      end else if (restart) begin
         a_lat <= a;
         b_lat <= b;
         x     <= a;
         y     <= b;
         done  <= 1'b0;
         state <= CALC;
`ifdef GCD_STEIN_EN
         k     <= '0;
`endif
      end else if (state == CALC) begin
         // result keeps the last completed value until this pair finishes
         if (finished) begin
            result <= final_value;
            done   <= 1'b1;
            state  <= DONE;
         end else begin
            x <= next_x;
            y <= next_y;
`ifdef GCD_STEIN_EN
            k <= next_k;
`endif
         end
      end
   end

endmodule

// File: tb/tb_gcd.sv
// Directed scoreboard bench for gcd: expected GCDs are queued on drive, popped on done.
module tb_gcd;
   import gcd_pkg::*;

   localparam int W = GCD_WIDTH;

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] a, b;
   logic [W-1:0] result;
   logic         done;

   int errors = 0;
   int checks = 0;
   logic [W-1:0] sb[$];
   logic [W-1:0] last_exp;
   int           cyc;
   int           bad;
   bit           first_low;

   gcd #(.WIDTH(W)) dut (
      .clk    (clk),
      .rst    (rst),
      .a      (a),
      .b      (b),
      .result (result),
      .done   (done)
   );

   always #5 clk = ~clk;

   initial begin
      #200us;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Drive a new pair on a falling edge; optionally queue its expected GCD.
   task automatic drive(input logic [W-1:0] av, input logic [W-1:0] bv, input bit push);
      @(negedge clk);
      a = av;
      b = bv;
      if (push) sb.push_back(gcd_ref(av, bv));
   endtask

   // Count posedges from capture until done, watching for a forbidden result value.
   task automatic wait_done(input string tag, input int max_cyc,
                            input bit use_forbid, input logic [W-1:0] forbid);
      cyc = 0;
      bad = 0;
      first_low = 1'b0;
      for (int n = 1; n <= max_cyc; n++) begin
         @(negedge clk);
         if (n == 1) first_low = !done;
         if (use_forbid && result === forbid) bad++;
         if (done) begin
            cyc = n;
            break;
         end
      end
      check({tag, " done"}, {31'd0, done}, 32'd1);
      if (use_forbid) check({tag, " forbidden result seen"}, bad, 0);
      check({tag, " scoreboard depth"}, sb.size(), 1);
      if (sb.size() > 0) begin
         last_exp = sb.pop_front();
         check({tag, " result"}, {24'd0, result}, {24'd0, last_exp});
      end
   endtask

   task automatic hold(input string tag, input int n_cyc);
      bad = 0;
      for (int n = 0; n < n_cyc; n++) begin
         @(negedge clk);
         if (result !== last_exp || done !== 1'b1) bad++;
      end
      check({tag, " hold cycles off"}, bad, 0);
   endtask

   initial begin
      rst = 1'b1;
      a   = '0;
      b   = '0;
      repeat (2) @(negedge clk);
      check("reset result", {24'd0, result}, 32'd0);
      check("reset done", {31'd0, done}, 32'd0);

      rst = 1'b0;
      a   = 8'd1;
      b   = 8'd1;
      sb.push_back(gcd_ref(8'd1, 8'd1));
      wait_done("g(1,1)", 10, 1'b0, '0);
      check("g(1,1) latency<=3", {31'd0, cyc <= 3}, 32'd1);
      hold("g(1,1)", 20);

      drive(8'd10, 8'd5, 1'b1);
      wait_done("g(10,5)", 50, 1'b0, '0);
      check("g(10,5) done fell", {31'd0, first_low}, 32'd1);
      check("g(10,5) const", {24'd0, result}, 32'd5);
      hold("g(10,5)", 15);

      drive(8'd12, 8'd8, 1'b1);
      wait_done("g(12,8)", 50, 1'b0, '0);
      check("g(12,8) done fell", {31'd0, first_low}, 32'd1);
      check("g(12,8) const", {24'd0, result}, 32'd4);
      hold("g(12,8)", 15);

      drive(8'd10, 8'd15, 1'b1);
      wait_done("g(10,15)", 50, 1'b0, '0);
      check("g(10,15) done fell", {31'd0, first_low}, 32'd1);
      check("g(10,15) const", {24'd0, result}, 32'd5);
      hold("g(10,15)", 15);

      drive(8'd0, 8'd7, 1'b1);
      wait_done("g(0,7)", 10, 1'b0, '0);
      check("g(0,7) const", {24'd0, result}, 32'd7);
      check("g(0,7) latency<=3", {31'd0, cyc <= 3}, 32'd1);

      drive(8'd7, 8'd0, 1'b1);
      wait_done("g(7,0)", 10, 1'b0, '0);
      check("g(7,0) latency<=3", {31'd0, cyc <= 3}, 32'd1);

      drive(8'd0, 8'd0, 1'b1);
      wait_done("g(0,0)", 10, 1'b0, '0);
      check("g(0,0) const", {24'd0, result}, 32'd0);
      check("g(0,0) latency<=3", {31'd0, cyc <= 3}, 32'd1);

      drive(8'd9, 8'd9, 1'b1);
      wait_done("g(9,9)", 10, 1'b0, '0);
      check("g(9,9) const", {24'd0, result}, 32'd9);
      check("g(9,9) latency<=3", {31'd0, cyc <= 3}, 32'd1);

      // Abort (200,3) mid-computation; its GCD of 1 must never appear.
      drive(8'd200, 8'd3, 1'b0);
      repeat (5) @(negedge clk);
      check("abort old result kept", {24'd0, result}, 32'd9);
      check("abort done low", {31'd0, done}, 32'd0);
      drive(8'd48, 8'd36, 1'b1);
      wait_done("g(48,36)", 50, 1'b1, 8'd1);
      check("g(48,36) const", {24'd0, result}, 32'd12);

      drive(8'd255, 8'd1, 1'b1);
      wait_done("g(255,1)", 400, 1'b0, '0);
`ifdef GCD_STEIN_EN
      check("g(255,1) latency<=18", {31'd0, cyc <= 18}, 32'd1);
`else
      check("g(255,1) latency", cyc, 256);
`endif

      drive(8'd100, 8'd75, 1'b1);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("mid-calc reset result", {24'd0, result}, 32'd0);
      check("mid-calc reset done", {31'd0, done}, 32'd0);
      rst = 1'b0;
      wait_done("g(100,75) after reset", 50, 1'b0, '0);
      check("g(100,75) const", {24'd0, result}, 32'd25);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
